// File: rtl/sha_multi_dispatch.sv
// Nonce scheduler for NUM_CORES SHA-256d cores: sweeps [nonce_start, nonce_end], one dispatch per cycle,
// first hit (core_H < target, lowest core on ties) wins. Optional SHA_HASHCOUNT_EN adds hash_count output.
module sha_multi_dispatch #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32,
  parameter int HASH_W    = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [NONCE_W-1:0]             nonce_start,
  input  logic [NONCE_W-1:0]             nonce_end,
  input  logic [HASH_W-1:0]              target,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES*HASH_W-1:0]    core_H,
  output logic                           busy,
  output logic                           done,
  output logic                           found,
  output logic [NONCE_W-1:0]             nonce,
  output logic [HASH_W-1:0]              winner_H
`ifdef SHA_HASHCOUNT_EN
  ,
  output logic [31:0]                    hash_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

  state_t               state_q, state_d;
  logic [NONCE_W:0]     next_nonce_q, next_nonce_d;
  logic [NONCE_W-1:0]   end_q;
  logic [HASH_W-1:0]    target_q;
  logic [NUM_CORES-1:0] inflight_q, inflight_d;
  logic [NONCE_W-1:0]   slot_nonce_q [NUM_CORES];
  logic                 done_q, found_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [HASH_W-1:0]    winner_q;

  logic [NUM_CORES-1:0] accepted, hit_vec;
  logic                 hit_any, taken, dispatch_ok;
  logic [NONCE_W-1:0]   win_nonce;
  logic [HASH_W-1:0]    win_H;
  logic                 latch, finish, accept_en, stop;

  // Descending scan so the lowest hitting core is the one left in win_*.
  always_comb begin
    accepted  = core_done & inflight_q;
    hit_vec   = '0;
    win_nonce = '0;
    win_H     = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (accepted[i] && (core_H[i*HASH_W +: HASH_W] < target_q)) begin
        hit_vec[i] = 1'b1;
        win_nonce  = slot_nonce_q[i];
        win_H      = core_H[i*HASH_W +: HASH_W];
      end
    end
  end

  assign hit_any = |hit_vec;

  // A core finishing this cycle counts as free, so it can be re-dispatched immediately.
  always_comb begin
    core_start  = '0;
    taken       = 1'b0;
    dispatch_ok = (state_q == S_RUN) && !hit_any && (next_nonce_q <= {1'b0, end_q});
    for (int i = 0; i < NUM_CORES; i++) begin
      if (dispatch_ok && !taken && !(inflight_q[i] && !accepted[i])) begin
        core_start[i] = 1'b1;
        taken         = 1'b1;
      end
    end
    core_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_nonce[i*NONCE_W +: NONCE_W] = core_start[i] ? next_nonce_q[NONCE_W-1:0] : slot_nonce_q[i];
    end
  end

  // FINISH is folded into the RUN/DRAIN exit edge so done rises one cycle after the last core_done;
  // the explicit FINISH state only serves the empty-range path.
  always_comb begin
    state_d      = state_q;
    next_nonce_d = next_nonce_q;
    inflight_d   = (inflight_q & ~accepted) | core_start;
    latch        = 1'b0;
    finish       = 1'b0;
    accept_en    = 1'b0;
    stop         = 1'b0;
    if (taken) next_nonce_d = next_nonce_q + (NONCE_W+1)'(1);
    case (state_q)
      S_IDLE: begin
        if (en) begin
          accept_en    = 1'b1;
          next_nonce_d = {1'b0, nonce_start};
          state_d      = (nonce_end < nonce_start) ? S_FINISH : S_RUN;
        end
      end
      S_RUN, S_DRAIN: begin
        latch = hit_any && !found_q;
        stop  = (state_q == S_DRAIN) || hit_any || (next_nonce_d > {1'b0, end_q});
        if (stop) begin
          if (inflight_d == '0) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_FINISH: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      next_nonce_q <= '0;
      end_q        <= '0;
      target_q     <= '0;
      inflight_q   <= '0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      nonce_q      <= '0;
      winner_q     <= '0;
      for (int i = 0; i < NUM_CORES; i++) slot_nonce_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      next_nonce_q <= next_nonce_d;
      inflight_q   <= inflight_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_start[i]) slot_nonce_q[i] <= next_nonce_q[NONCE_W-1:0];
      end
      if (accept_en) begin
        end_q    <= nonce_end;
        target_q <= target;
        done_q   <= 1'b0;
        found_q  <= 1'b0;
      end
      if (latch) begin
        found_q  <= 1'b1;
        nonce_q  <= win_nonce;
        winner_q <= win_H;
      end
      if (finish) done_q <= 1'b1;
    end
  end

`ifdef SHA_HASHCOUNT_EN
  logic [32:0] hc_sum;

  always_comb begin
    hc_sum = {1'b0, hash_count};
    for (int i = 0; i < NUM_CORES; i++) begin
      if (accepted[i]) hc_sum = hc_sum + 33'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          hash_count <= '0;
    else if (accept_en) hash_count <= '0;
    else                hash_count <= hc_sum[32] ? 32'hFFFF_FFFF : hc_sum[31:0];
  end
`endif

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = done_q;
  assign found    = found_q;
  assign nonce    = nonce_q;
  assign winner_H = winner_q;

endmodule

// File: tb/tb_sha_multi_dispatch.sv
// Randomized bench for sha_multi_dispatch: behavioural core array with random latencies,
// scoreboard of dispatched nonces, expected winner and done timing.
`timescale 1ns/1ps
module tb_sha_multi_dispatch;
  localparam int NC = 4;
  localparam int NW = 32;
  localparam int HW = 256;
  localparam logic [HW-1:0] TGT = 256'd1 << 200;

  logic clk = 1'b0;
  logic reset, en;
  logic [NW-1:0]    nonce_start, nonce_end;
  logic [HW-1:0]    target;
  logic [NC-1:0]    core_start, core_done;
  logic [NC*NW-1:0] core_nonce;
  logic [NC*HW-1:0] core_H;
  logic             busy, done, found;
  logic [NW-1:0]    nonce;
  logic [HW-1:0]    winner_H;
`ifdef SHA_HASHCOUNT_EN
  logic [31:0]      hash_count;
`endif

  sha_multi_dispatch #(.NUM_CORES(NC), .NONCE_W(NW), .HASH_W(HW)) dut (
    .clk(clk), .reset(reset), .en(en),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .core_start(core_start), .core_nonce(core_nonce),
    .core_done(core_done), .core_H(core_H),
    .busy(busy), .done(done), .found(found), .nonce(nonce), .winner_H(winner_H)
`ifdef SHA_HASHCOUNT_EN
    , .hash_count(hash_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  bit            m_busy    [NC];
  logic [NW-1:0] m_nonce   [NC];
  int            m_cnt     [NC];
  int            fixed_lat [NC];
  logic [NW-1:0] hit_q [$];
  logic [NW-1:0] eq_nonce;
  bit            eq_en;
  logic [HW-1:0] cur_tgt;

  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Hit nonces hash just below the target, eq_nonce hashes exactly to it, everything else far above.
  function automatic logic [HW-1:0] hash_of(input logic [NW-1:0] n);
    foreach (hit_q[k]) if (hit_q[k] == n) return cur_tgt - HW'(n) - HW'(1);
    if (eq_en && n == eq_nonce) return cur_tgt;
    return ~HW'(n);
  endfunction

  task automatic do_run(input string name, input logic [NW-1:0] s, input logic [NW-1:0] e,
                        input logic [HW-1:0] tgt, input bit noise);
    logic [NW-1:0] starts [$];
    logic [HW-1:0] h, exp_H;
    logic [NW-1:0] exp_nonce, cn;
    longint        range_n;
    int hit_cycle, last_acc, acc_cnt, done_cycle, late, bad_sched, bad_order, want, still_busy;
    hit_cycle = -1; last_acc = 0; acc_cnt = 0; done_cycle = -1;
    late = 0; bad_sched = 0; bad_order = 0; still_busy = 0;
    exp_nonce = '0; exp_H = '0;
    range_n = (e >= s) ? longint'(e) - longint'(s) + 1 : 0;
    cur_tgt = tgt;
    en = 1'b1; nonce_start = s; nonce_end = e; target = tgt;
    @(posedge clk); #1;
    en = 1'b0; nonce_start = $urandom; nonce_end = $urandom; target = {8{$urandom}};
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (cyc == 1) check({name, "_busy_after_en"}, busy, range_n > 0);
      if (done) begin done_cycle = cyc; break; end
      en = noise && ($urandom_range(0, 3) == 0);
      core_done = '0;
      for (int i = 0; i < NC; i++) begin
        if (m_busy[i] && m_cnt[i] == 0) begin
          h = hash_of(m_nonce[i]);
          core_done[i] = 1'b1;
          core_H[i*HW +: HW] = h;
          m_busy[i] = 1'b0;
          acc_cnt++;
          last_acc = cyc;
          if (h < tgt && hit_cycle < 0) begin
            hit_cycle = cyc; exp_nonce = m_nonce[i]; exp_H = h;
          end
        end else if (m_busy[i]) begin
          m_cnt[i]--;
        end else if (noise && $urandom_range(0, 4) == 0) begin
          core_done[i] = 1'b1;
          core_H[i*HW +: HW] = '0;
        end
      end
      want = -1;
      if (hit_cycle < 0 && longint'(starts.size()) < range_n)
        for (int i = NC-1; i >= 0; i--) if (!m_busy[i]) want = i;
      #2;
      if (hit_cycle != cyc) begin
        if (want < 0) begin
          if (core_start != '0) bad_sched++;
        end else if (core_start != (NC'(1) << want)) bad_sched++;
      end
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          cn = core_nonce[i*NW +: NW];
          if (m_busy[i]) bad_sched++;
          if (cn != s + NW'(starts.size())) bad_order++;
          if (hit_cycle >= 0 && cyc > hit_cycle) late++;
          starts.push_back(cn);
          m_busy[i] = 1'b1;
          m_nonce[i] = cn;
          m_cnt[i] = (fixed_lat[i] >= 0) ? fixed_lat[i] : int'($urandom_range(0, 4));
        end
      end
      @(posedge clk); #1;
    end
    en = 1'b0;
    core_done = '0;
    for (int i = 0; i < NC; i++) if (m_busy[i]) still_busy++;
    check({name, "_done_seen"}, done_cycle > 0, 1'b1);
    check({name, "_done_cycle"}, done_cycle, (range_n == 0) ? 2 : last_acc + 1);
    check({name, "_busy_at_done"}, busy, 1'b0);
    check({name, "_found"}, found, hit_cycle >= 0);
    check({name, "_sched_errs"}, bad_sched, 0);
    check({name, "_order_errs"}, bad_order, 0);
    check({name, "_cores_idle"}, still_busy, 0);
    if (hit_cycle >= 0) begin
      check({name, "_nonce"}, nonce, exp_nonce);
      check({name, "_winner_H"}, winner_H, exp_H);
      check({name, "_starts_after_hit"}, late, 0);
    end else begin
      check({name, "_start_count"}, starts.size(), range_n);
    end
`ifdef SHA_HASHCOUNT_EN
    check({name, "_hash_count"}, hash_count, acc_cnt);
`endif
    repeat (3) @(posedge clk);
    #1;
    check({name, "_hold"}, {done, found, busy}, {1'b1, hit_cycle >= 0, 1'b0});
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; nonce_start = '0; nonce_end = '0; target = '0;
    core_done = '0; core_H = '0; eq_en = 1'b0; eq_nonce = '0; cur_tgt = '0;
    for (int i = 0; i < NC; i++) begin fixed_lat[i] = -1; m_busy[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, found, core_start}, '0);
    check("reset_nonce", nonce, '0);
    check("reset_winner", winner_H, '0);
    check("reset_core_nonce", core_nonce, '0);
`ifdef SHA_HASHCOUNT_EN
    check("reset_hash_count", hash_count, '0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    hit_q.delete();
    do_run("t1", 0, 7, '0, 1'b0);

    hit_q = '{32'd5};
    do_run("t2", 0, 7, TGT, 1'b1);
    check("t2_winner_is_5", nonce, 5);

    hit_q = '{32'd9, 32'd11};
    fixed_lat = '{6, 3, 6, 1};
    do_run("t3", 8, 15, TGT, 1'b0);
    check("t3_core1_wins", nonce, 9);
    for (int i = 0; i < NC; i++) fixed_lat[i] = -1;

    hit_q.delete();
    do_run("t4", 32'hFFFF_FFFE, 32'hFFFF_FFFF, TGT, 1'b1);
    do_run("t5", 10, 3, TGT, 1'b1);

    eq_en = 1'b1; eq_nonce = 20;
    do_run("eq_target", 16, 27, TGT, 1'b1);
    eq_en = 1'b0;

    for (int r = 0; r < 6; r++) begin
      logic [NW-1:0] s;
      int len;
      len = $urandom_range(1, 40);
      s = (r == 5) ? (32'hFFFF_FFFF - 32'(len) + 32'd1) : NW'($urandom_range(0, 5000));
      hit_q.delete();
      repeat ($urandom_range(0, 2)) hit_q.push_back(s + NW'($urandom_range(0, len - 1)));
      do_run("rnd", s, s + NW'(len - 1), TGT, 1'b1);
    end

    hit_q.delete();
    en = 1'b1; nonce_start = 0; nonce_end = 99; target = TGT;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_busy_before_reset", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t6_reset_ctrl", {busy, done, found, core_start}, '0);
    check("t6_reset_core_nonce", core_nonce, '0);
    @(posedge clk); #1;
    check("t6_reset_held", {busy, done, found, core_start}, '0);
    check("t6_reset_results", {nonce, winner_H[31:0]}, '0);
    reset = 1'b0;
    for (int i = 0; i < NC; i++) m_busy[i] = 1'b0;
    @(posedge clk); #1;
    hit_q = '{32'd3};
    do_run("t6_restart", 0, 7, TGT, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
